vxe_axi_switch_rq_arb: RTL and testbench
========================================

Name: vxe_axi_switch_rq_arb

Overview:
- Round-robin arbiter that shares the single upstream request channel (rqa address/control, rqd write data) of the AXI switch between N request clients, e.g. vector processing units.
- Sits between the clients' outgoing request FIFOs and the AXI switch upstream unit.
- Presents the FIFO-style vld/data/rd interface on both sides.
- Keeps every write rqa atomically paired with its rqd: no other client's traffic is interleaved between the two.

Parameters:
- NCLI, 4, number of clients (2..8).
- CLI_W, 2, client index width, ceil(log2(NCLI)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_rqa_vld  in  NCLI  per-client rqa valid.
- i_rqa  in  NCLI*44  per-client rqa; client k occupies bits [44k+43:44k].
- o_rqa_rd  out  NCLI  per-client rqa read; one-hot or zero.
- i_rqd_vld  in  NCLI  per-client rqd valid.
- i_rqd  in  NCLI*72  per-client rqd; client k occupies bits [72k+71:72k].
- o_rqd_rd  out  NCLI  per-client rqd read; one-hot or zero.
- o_m_rqa_vld  out  1  merged rqa valid.
- o_m_rqa  out  44  merged rqa.
- i_m_rqa_rd  in  1  downstream rqa read.
- o_m_rqd_vld  out  1  merged rqd valid.
- o_m_rqd  out  72  merged rqd.
- i_m_rqd_rd  in  1  downstream rqd read.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Transfer rule, both sides: a beat moves in the cycle where vld && rd. Source data is consumed in the same cycle that rd is sampled high.
- Downstream may hold rd high with vld low; this is not a transfer.
- Output stage: one holding register each for rqa and rqd.
  - Slot "free" = !o_m_*_vld || i_m_*_rd.
  - Latency from client transfer to o_m_* valid is 1 cycle.
  - Sustained throughput is 1 rqa per cycle for reads.
- rnw is taken from the arbitrated rqa through an instance of vxe_txnreqa_decoder. rqa/rqd contents pass through unmodified.
- FSM state ARB:
  - Winner = first k with i_rqa_vld[k], scanning from (last+1) mod NCLI with wrap.
  - If the rqa slot is free: o_rqa_rd[winner]=1 (combinational), the slot loads i_rqa[winner], and last<=winner.
  - If winner is a read, stay in ARB.
  - If winner is a write, lock owner<=winner and go to DATA.
  - If no client is valid or the slot is not free, all rd=0 and last is unchanged.
- FSM state DATA:
  - Only the owner is served; all o_rqa_rd=0.
  - When i_rqd_vld[owner] && rqd slot free: o_rqd_rd[owner]=1, the slot loads i_rqd[owner], and the FSM goes to ARB.
  - The owner's rqd may lag its rqa by any number of cycles; the FSM waits.
- Simultaneous events: a slot load and a downstream pop in the same cycle is legal (register replaced). Pop without load clears vld.
- An rqd arriving on a client that is not the owner, or while in ARB, is not read.
- Reset (including mid-write in DATA):
  - FSM goes to ARB, last=NCLI-1 (client 0 wins first).
  - o_m_rqa_vld=0, o_m_rqd_vld=0; o_m_rqa and o_m_rqd are cleared to 0.
  - o_rqa_rd and o_rqd_rd are forced to 0 while rst is high.
  - The pending pair is dropped; clients are reset together with the switch.
- At most one bit of o_rqa_rd | o_rqd_rd is high in any cycle.

Optional Feature:
- Macro: VXE_AXI_SWITCH_RQ_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest valid index wins. The last register is not implemented, and client 0 can starve others.
- Undefined: round-robin as above.
- Write pairing and latency are identical in both modes.

Decomposition:
- Shared package holds:
  - RQA width 44 and RQD width 72.
  - FSM state encoding: ARB=1'b0, DATA=1'b1.
- One natural sub-module: vxe_rr_picker, a combinational rotate-priority encoder with inputs (req[NCLI], last[CLI_W]) and outputs (grant one-hot, grant index, any).
- The FIXED_PRIO mode ties last to NCLI-1 inside the picker.

Test Plan:
- Reads from all 4 clients continuously, i_m_rqa_rd=1 → grants 0,1,2,3,0…; o_m_rqa_vld stays high; 1 rqa per cycle.
- Client 1 write rqa at cycle 0, its rqd at cycle 5, client 2 reads valid throughout → client 2 gets no rd in cycles 1-5; o_m_rqd = client 1 data; client 2 is served in the cycle after the rqd transfer.
- i_m_rqa_rd=0 for 3 cycles with all clients valid → all o_rqa_rd=0; o_m_rqa is held stable; no beat lost or duplicated.
- i_rqd_vld[3]=1 with no client 3 write pending → o_rqd_rd[3] never asserts.
- rst asserted in DATA → next cycle: both vld=0, all rd=0; client 0 wins first after release.
- With VXE_AXI_SWITCH_RQ_ARB_FIXED_PRIO_EN defined and clients 0 and 2 both reading → only client 0 is granted while i_rqa_vld[0]=1.

Source files
------------

// File: rtl/vxe_axi_switch_rq_arb_pkg.sv
// Shared widths, rqa field positions and FSM encoding for the upstream request arbiter.
package vxe_axi_switch_rq_arb_pkg;
  localparam int RQA_W       = 44;
  localparam int RQD_W       = 72;
  // Read/not-write flag of a transaction rqa beat (1 = read).
  localparam int RQA_RNW_BIT = 43;

  typedef enum logic {
    ARB  = 1'b0,
    DATA = 1'b1
  } arb_state_e;
endpackage

// File: rtl/vxe_axi_switch_rq_arb_rr_picker.sv
// Combinational rotate-priority encoder: first requester after 'last' wins, with wrap.
// VXE_AXI_SWITCH_RQ_ARB_FIXED_PRIO_EN pins the rotation base so the lowest index always wins.
module vxe_rr_picker #(
  parameter int NCLI  = 4,
  parameter int CLI_W = 2
) (
  input  logic [NCLI-1:0]  req,
  input  logic [CLI_W-1:0] last,
  output logic [NCLI-1:0]  gnt,
  output logic [CLI_W-1:0] gnt_idx,
  output logic             any
);
  logic [CLI_W-1:0] base;

`ifdef VXE_AXI_SWITCH_RQ_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;
  assign base = CLI_W'(NCLI-1);
`else
  assign base = last;
`endif

  // Scan from farthest to nearest so the nearest requester after base overwrites.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = |req;
    for (int i = NCLI; i >= 1; i--) begin
      if (req[(int'(base) + i) % NCLI]) begin
        gnt                             = '0;
        gnt[(int'(base) + i) % NCLI]    = 1'b1;
        gnt_idx                         = CLI_W'((int'(base) + i) % NCLI);
      end
    end
  end
endmodule

// File: rtl/vxe_txnreqa_decoder.sv
// Extracts the read/not-write flag from a transaction request-address beat.
module vxe_txnreqa_decoder
  import vxe_axi_switch_rq_arb_pkg::*;
(
  input  logic [RQA_W-1:0] rqa,
  output logic             rnw
);
  assign rnw = rqa[RQA_RNW_BIT];
endmodule

// File: rtl/vxe_axi_switch_rq_arb.sv
// Shares the AXI switch upstream rqa/rqd channel between NCLI clients, keeping write rqa/rqd pairs atomic.
// Build option: VXE_AXI_SWITCH_RQ_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module vxe_axi_switch_rq_arb
  import vxe_axi_switch_rq_arb_pkg::*;
#(
  parameter int NCLI  = 4,
  parameter int CLI_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCLI-1:0]       i_rqa_vld,
  input  logic [NCLI*RQA_W-1:0] i_rqa,
  output logic [NCLI-1:0]       o_rqa_rd,
  input  logic [NCLI-1:0]       i_rqd_vld,
  input  logic [NCLI*RQD_W-1:0] i_rqd,
  output logic [NCLI-1:0]       o_rqd_rd,
  output logic                  o_m_rqa_vld,
  output logic [RQA_W-1:0]      o_m_rqa,
  input  logic                  i_m_rqa_rd,
  output logic                  o_m_rqd_vld,
  output logic [RQD_W-1:0]      o_m_rqd,
  input  logic                  i_m_rqd_rd
);
  logic [NCLI-1:0][RQA_W-1:0] rqa_arr;
  logic [NCLI-1:0][RQD_W-1:0] rqd_arr;
  assign rqa_arr = i_rqa;
  assign rqd_arr = i_rqd;

  arb_state_e       state, state_nxt;
  logic [CLI_W-1:0] owner;
  logic [CLI_W-1:0] last;
  logic [NCLI-1:0]  gnt;
  logic [CLI_W-1:0] gnt_idx;
  logic             any;
  logic [RQA_W-1:0] sel_rqa;
  logic             rnw;
  logic             rqa_free, rqd_free, rqa_take, rqd_take;

  vxe_rr_picker #(.NCLI(NCLI), .CLI_W(CLI_W)) u_picker (
    .req     (i_rqa_vld),
    .last    (last),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign sel_rqa = rqa_arr[gnt_idx];

  vxe_txnreqa_decoder u_dec (
    .rqa (sel_rqa),
    .rnw (rnw)
  );

  assign rqa_free = !o_m_rqa_vld || i_m_rqa_rd;
  assign rqd_free = !o_m_rqd_vld || i_m_rqd_rd;
  assign rqa_take = !rst && (state == ARB)  && any && rqa_free;
  assign rqd_take = !rst && (state == DATA) && i_rqd_vld[owner] && rqd_free;

  always_comb begin
    state_nxt = state;
    o_rqa_rd  = '0;
    o_rqd_rd  = '0;
    case (state)
      ARB: if (rqa_take) begin
        o_rqa_rd = gnt;
        if (!rnw) state_nxt = DATA;
      end
      DATA: if (rqd_take) begin
        o_rqd_rd  = NCLI'(1) << owner;
        state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB;
      owner       <= '0;
      o_m_rqa_vld <= 1'b0;
      o_m_rqa     <= '0;
      o_m_rqd_vld <= 1'b0;
      o_m_rqd     <= '0;
    end else begin
      state <= state_nxt;
      if (rqa_take) begin
        o_m_rqa_vld <= 1'b1;
        o_m_rqa     <= sel_rqa;
        if (!rnw) owner <= gnt_idx;
      end else if (i_m_rqa_rd) begin
        o_m_rqa_vld <= 1'b0;
      end
      if (rqd_take) begin
        o_m_rqd_vld <= 1'b1;
        o_m_rqd     <= rqd_arr[owner];
      end else if (i_m_rqd_rd) begin
        o_m_rqd_vld <= 1'b0;
      end
    end
  end

`ifdef VXE_AXI_SWITCH_RQ_ARB_FIXED_PRIO_EN
  assign last = CLI_W'(NCLI-1);
`else
  // Reset value NCLI-1 makes client 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst)           last <= CLI_W'(NCLI-1);
    else if (rqa_take) last <= gnt_idx;
  end
`endif
endmodule

// File: tb/tb_vxe_axi_switch_rq_arb.sv
// Directed bench for vxe_axi_switch_rq_arb: round-robin order, stalls, write pairing, reset in DATA.
module tb_vxe_axi_switch_rq_arb;
  localparam int NCLI = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCLI-1:0]   i_rqa_vld, o_rqa_rd, i_rqd_vld, o_rqd_rd;
  logic [NCLI*44-1:0] i_rqa;
  logic [NCLI*72-1:0] i_rqd;
  logic              o_m_rqa_vld, i_m_rqa_rd, o_m_rqd_vld, i_m_rqd_rd;
  logic [43:0]       o_m_rqa;
  logic [71:0]       o_m_rqd;

  // Client sources: payload = {rnw, 0, client, seq}; seq advances when the arbiter reads.
  logic [NCLI-1:0]       rnw;
  logic [NCLI-1:0][7:0]  seq_a, seq_d;
  logic [NCLI-1:0][43:0] rqa_arr;
  logic [NCLI-1:0][71:0] rqd_arr;
  assign i_rqa = rqa_arr;
  assign i_rqd = rqd_arr;

  always_comb begin
    rqa_arr = '0;
    rqd_arr = '0;
    for (int k = 0; k < NCLI; k++) begin
      rqa_arr[k] = {rnw[k], 27'd0, 8'(k), seq_a[k]};
      rqd_arr[k] = {56'hDD, 8'(k), seq_d[k]};
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NCLI; k++) begin
      if (rst) begin
        seq_a[k] <= 8'd0;
        seq_d[k] <= 8'd0;
      end else begin
        if (o_rqa_rd[k]) seq_a[k] <= seq_a[k] + 8'd1;
        if (o_rqd_rd[k]) seq_d[k] <= seq_d[k] + 8'd1;
      end
    end
  end

  vxe_axi_switch_rq_arb #(.NCLI(NCLI), .CLI_W(2)) dut (
    .clk(clk), .rst(rst),
    .i_rqa_vld(i_rqa_vld), .i_rqa(i_rqa), .o_rqa_rd(o_rqa_rd),
    .i_rqd_vld(i_rqd_vld), .i_rqd(i_rqd), .o_rqd_rd(o_rqd_rd),
    .o_m_rqa_vld(o_m_rqa_vld), .o_m_rqa(o_m_rqa), .i_m_rqa_rd(i_m_rqa_rd),
    .o_m_rqd_vld(o_m_rqd_vld), .o_m_rqd(o_m_rqd), .i_m_rqd_rd(i_m_rqd_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_rqa_vld = '0; i_rqd_vld = '0; rnw = '1;
    i_m_rqa_rd = 1'b1; i_m_rqd_rd = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  int gexp [6] = '{0, 1, 2, 3, 0, 1};
  int sexp [6] = '{0, 0, 0, 0, 1, 1};

  initial begin
    // Reset: rd forced low even with every client valid.
    do_reset();
    rst = 1'b1; i_rqa_vld = '1; i_rqd_vld = '1;
    settle();
    chk("rst_rqa_rd", 72'(o_rqa_rd), 72'h0);
    chk("rst_rqd_rd", 72'(o_rqd_rd), 72'h0);
    tick();
    chk("rst_rqa_vld", 72'(o_m_rqa_vld), 72'h0);
    chk("rst_rqd_vld", 72'(o_m_rqd_vld), 72'h0);
    chk("rst_rqa_data", 72'(o_m_rqa), 72'h0);
    chk("rst_rqd_data", o_m_rqd, 72'h0);

    // Continuous reads from all clients: 0,1,2,3,0,1 one per cycle.
    do_reset();
    i_rqa_vld = '1;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("rr_grant", 72'(o_rqa_rd), 72'(4'b1 << gexp[i]));
      tick();
      chk("rr_vld", 72'(o_m_rqa_vld), 72'h1);
      chk("rr_data", 72'(o_m_rqa[15:0]), 72'((gexp[i] << 8) | sexp[i]));
    end

    // Downstream stall for 3 cycles: no reads, output held, then resumes at client 1.
    do_reset();
    i_rqa_vld = '1;
    settle();
    chk("stall_first", 72'(o_rqa_rd), 72'h1);
    tick();
    i_m_rqa_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_rd", 72'(o_rqa_rd), 72'h0);
      tick();
      chk("stall_hold", 72'(o_m_rqa[15:0]), 72'h0000);
      chk("stall_vld", 72'(o_m_rqa_vld), 72'h1);
    end
    i_m_rqa_rd = 1'b1;
    settle();
    chk("stall_resume", 72'(o_rqa_rd), 72'h2);
    tick();
    chk("stall_next", 72'(o_m_rqa[15:0]), 72'h0100);

    // Client 1 write, rqd five cycles later; client 2 reads held off until pair completes.
    do_reset();
    rnw[1] = 1'b0;
    i_rqa_vld = 4'b0110; i_rqd_vld = 4'b1000;
    settle();
    chk("wr_grant", 72'(o_rqa_rd), 72'h2);
    tick();
    i_rqa_vld = 4'b0100;
    chk("wr_rqa", 72'({o_m_rqa[43], o_m_rqa[15:0]}), 72'h0_0100);
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("wr_wait_rqa_rd", 72'(o_rqa_rd), 72'h0);
      chk("wr_wait_rqd_rd", 72'(o_rqd_rd), 72'h0);
      tick();
    end
    i_rqd_vld = 4'b1010;
    settle();
    chk("wr_data_rqa_rd", 72'(o_rqa_rd), 72'h0);
    chk("wr_data_rqd_rd", 72'(o_rqd_rd), 72'h2);
    tick();
    i_rqd_vld = 4'b1000;
    chk("wr_rqd_vld", 72'(o_m_rqd_vld), 72'h1);
    chk("wr_rqd_data", o_m_rqd, {56'hDD, 16'h0100});
    settle();
    chk("wr_after_grant", 72'(o_rqa_rd), 72'h4);
    chk("wr_stray_rqd", 72'(o_rqd_rd), 72'h0);
    tick();
    chk("wr_after_data", 72'(o_m_rqa[15:0]), 72'h0200);
    chk("wr_rqd_pop", 72'(o_m_rqd_vld), 72'h0);

    // Reset while waiting in DATA for client 2's rqd.
    do_reset();
    rnw[2] = 1'b0;
    i_rqa_vld = 4'b0100;
    settle();
    chk("rd_wr_grant", 72'(o_rqa_rd), 72'h4);
    tick();
    rst = 1'b1; rnw = '1; i_rqa_vld = '1; i_rqd_vld = 4'b0100;
    settle();
    chk("rd_rst_rqa_rd", 72'(o_rqa_rd), 72'h0);
    chk("rd_rst_rqd_rd", 72'(o_rqd_rd), 72'h0);
    tick();
    rst = 1'b0;
    chk("rd_rqa_vld", 72'(o_m_rqa_vld), 72'h0);
    chk("rd_rqd_vld", 72'(o_m_rqd_vld), 72'h0);
    settle();
    chk("rd_first", 72'(o_rqa_rd), 72'h1);
    chk("rd_no_rqd", 72'(o_rqd_rd), 72'h0);
    tick();
    chk("rd_first_data", 72'(o_m_rqa[15:0]), 72'h0000);

    // Clients 0 and 2 both reading.
    do_reset();
    i_rqa_vld = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      settle();
`ifdef VXE_AXI_SWITCH_RQ_ARB_FIXED_PRIO_EN
      chk("prio_grant", 72'(o_rqa_rd), 72'h1);
`else
      chk("prio_grant", 72'(o_rqa_rd), (i % 2 == 0) ? 72'h1 : 72'h4);
`endif
      tick();
    end
    i_rqa_vld = 4'b0100;
    settle();
    chk("prio_other", 72'(o_rqa_rd), 72'h4);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
